// File: rtl/seq_builder_pkg.sv
// Shared definitions for the secret-sequence builder: FSM encoding and the
// symbol/sequence defaults also used by the input checker.
package seq_builder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int SEQ_LEN_DEF = 8;
  localparam int SYM_W_DEF   = 2;

  // A terminal count of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/seq_builder_cycle_timer.sv
// Modulo-COUNT cycle counter: counts while enabled, held at zero by clear,
// and flags the last cycle of each period with a combinational done pulse.
module cycle_timer
  import seq_builder_pkg::*;
#(
  parameter int COUNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = cnt_width(COUNT);
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] cnt;

  assign done = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_builder.sv
// Samples the LFSR every STRIDE cycles to build a round's symbol sequence,
// plays it on a one-hot LED bank, then holds it for the checker's read port.
module seq_builder
  import seq_builder_pkg::*;
#(
  parameter int SEQ_LEN     = SEQ_LEN_DEF,
  parameter int SYM_W       = SYM_W_DEF,
  parameter int STRIDE      = 8,
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 lfsr_in,
  input  logic                       start,
  input  logic [$clog2(SEQ_LEN)-1:0] rd_idx,
  output logic [SYM_W-1:0]           rd_sym,
  output logic [(1<<SYM_W)-1:0]      led,
  output logic                       busy,
  output logic                       seq_ready,
  output logic [2:0]                 dbg_state
);

  localparam int IW    = $clog2(SEQ_LEN);
  localparam int LED_W = 1 << SYM_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);

  state_t           state;
  logic [IW-1:0]    sym_idx;
  logic [SYM_W-1:0] sym_buf [SEQ_LEN];
  logic             stride_done;
  logic             hold_done;
  logic             gap_done;
  logic             unused_lfsr;

  assign unused_lfsr = ^lfsr_in[7:SYM_W];
  assign dbg_state   = state;

  // Each timer is held at zero outside its own state, so entering the state
  // always starts a fresh period.
  cycle_timer #(.COUNT(STRIDE)) u_stride_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_CAPTURE),
    .enable (state == ST_CAPTURE),
    .done   (stride_done)
  );

  cycle_timer #(.COUNT(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_SHOW_ON),
    .enable (state == ST_SHOW_ON),
    .done   (hold_done)
  );

  cycle_timer #(.COUNT(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_SHOW_OFF),
    .enable (state == ST_SHOW_OFF),
    .done   (gap_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sym_idx   <= '0;
      rd_sym    <= '0;
      led       <= '0;
      busy      <= 1'b0;
      seq_ready <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) sym_buf[i] <= '0;
    end else begin
      rd_sym <= sym_buf[rd_idx];
      // led and seq_ready trail the state by one cycle; a held start still
      // leaves one visible seq_ready cycle before the next round.
      seq_ready <= (state == ST_DONE);
      led       <= (state == ST_SHOW_ON) ? (LED_W'(1) << sym_buf[sym_idx]) : '0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CAPTURE;
            sym_idx <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (stride_done) begin
            sym_buf[sym_idx] <= lfsr_in[SYM_W-1:0];
            if (sym_idx == LAST_IDX) begin
              state   <= ST_SHOW_ON;
              sym_idx <= '0;
            end else begin
              sym_idx <= sym_idx + 1'b1;
            end
          end
        end
        ST_SHOW_ON: begin
          if (hold_done) state <= ST_SHOW_OFF;
        end
        ST_SHOW_OFF: begin
          if (gap_done) begin
            if (sym_idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_SHOW_ON;
              sym_idx <= sym_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_builder.sv
// Self-checking bench for seq_builder with short timing (4 symbols, stride 8,
// hold 4, gap 2); expectations come from the round timeline formulas.
module tb_seq_builder;

  localparam int SEQ_LEN   = 4;
  localparam int SYM_W     = 2;
  localparam int STRIDE    = 8;
  localparam int HOLD      = 4;
  localparam int GAP       = 2;
  localparam int IW        = 2;
  localparam int LED_W     = 4;
  localparam int PER       = HOLD + GAP;
  localparam int LED_START = STRIDE * SEQ_LEN + 1;
  localparam int RDY       = LED_START + SEQ_LEN * PER;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       lfsr_in = 8'h00;
  logic [IW-1:0]    rd_idx = '0;
  logic [SYM_W-1:0] rd_sym;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             seq_ready;
  logic [2:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SYM_W-1:0] exp_q[$];
  logic [7:0]       lfsr_state = 8'h01;

  seq_builder #(
    .SEQ_LEN(SEQ_LEN), .SYM_W(SYM_W), .STRIDE(STRIDE),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .lfsr_in(lfsr_in), .start(start),
    .rd_idx(rd_idx), .rd_sym(rd_sym), .led(led), .busy(busy),
    .seq_ready(seq_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Runs one round from a negedge. mode: 0 const A6, 1 forced 0/3/1/2
  // pattern, 2 stepping LFSR, 3 random. hold keeps start high into a second
  // round; reset_at pulls reset low before that edge and returns after it.
  task automatic run_round(input int mode, input int ncyc, input bit hold,
                           input bit prev_done, input int pulse_a,
                           input int pulse_b, input int reset_at);
    int r0, kk, t;
    bit pd;
    logic [LED_W-1:0] e_led;
    logic e_busy, e_rdy;
    r0 = 0;
    pd = prev_done;
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      if (hold && k == RDY) begin
        r0 = RDY;
        pd = 1'b1;
        exp_q.delete();
      end
      kk = k - r0;
      start = (k == 0) || (hold && k < RDY + 3) || (k == pulse_a) || (k == pulse_b);
      case (mode)
        0: lfsr_in = 8'hA6;
        1: begin
          lfsr_in = 8'($urandom_range(0, 255));
          if (kk == 8)  lfsr_in[1:0] = 2'd0;
          if (kk == 16) lfsr_in[1:0] = 2'd3;
          if (kk == 24) lfsr_in[1:0] = 2'd1;
          if (kk == 32) lfsr_in[1:0] = 2'd2;
        end
        2: lfsr_in = lfsr_state;
        default: lfsr_in = 8'($urandom_range(0, 255));
      endcase
      if (kk > 0 && kk % STRIDE == 0 && kk / STRIDE <= SEQ_LEN)
        exp_q.push_back(lfsr_in[SYM_W-1:0]);
      if (k == reset_at) reset = 1'b0;
      @(posedge clk);
      if (mode == 2) lfsr_state = lfsr_next(lfsr_state);
      #1;
      if (k == reset_at) break;
      e_busy = (kk < RDY - 1);
      e_rdy  = (kk == 0 && pd) || (kk >= RDY);
      t      = kk - LED_START;
      e_led  = '0;
      if (t >= 0 && t < SEQ_LEN * PER && (t % PER) < HOLD)
        e_led = LED_W'(1) << exp_q[t / PER];
      checks += 3;
      if (led !== e_led) begin
        errors++;
        $display("FAIL led k=%0d got %b exp %b", kk, led, e_led);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy k=%0d got %b exp %b", kk, busy, e_busy);
      end
      if (seq_ready !== e_rdy) begin
        errors++;
        $display("FAIL seq_ready k=%0d got %b exp %b", kk, seq_ready, e_rdy);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_readback(input string name);
    for (int i = 0; i < SEQ_LEN; i++) begin
      rd_idx = IW'(i);
      @(posedge clk);
      #1;
      checks++;
      if (rd_sym !== exp_q[i]) begin
        errors++;
        $display("FAIL %s rd_sym[%0d] got %0d exp %0d", name, i, rd_sym, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (led !== '0)      begin errors++; $display("FAIL reset_led got %b exp 0", led); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (seq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", seq_ready); end
    if (rd_sym !== '0)   begin errors++; $display("FAIL reset_rd_sym got %0d exp 0", rd_sym); end
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_const_a6();
    run_round(0, RDY + 2, 1'b0, 1'b0, -1, -1, -1);
    for (int i = 0; i < SEQ_LEN; i++) begin
      checks++;
      if (exp_q[i] !== 2'b10) begin
        errors++;
        $display("FAIL a6_model sym[%0d] got %0d exp 2", i, exp_q[i]);
      end
    end
    check_readback("a6");
  endtask

  task automatic test_pattern();
    logic [SYM_W-1:0] want [SEQ_LEN];
    want = '{2'd0, 2'd3, 2'd1, 2'd2};
    run_round(1, RDY + 2, 1'b0, 1'b1, -1, -1, -1);
    for (int i = 0; i < SEQ_LEN; i++) begin
      rd_idx = IW'(i);
      @(posedge clk);
      #1;
      checks++;
      if (rd_sym !== want[i]) begin
        errors++;
        $display("FAIL pattern rd_sym[%0d] got %0d exp %0d", i, rd_sym, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_real_lfsr();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lfsr_state = 8'($urandom_range(1, 255));
    @(negedge clk);
    run_round(2, RDY + 2, 1'b0, 1'b0, -1, -1, -1);
    check_readback("lfsr");
  endtask

  task automatic test_start_ignored();
    run_round(3, RDY + 2, 1'b0, 1'b1, 12, LED_START + 1, -1);
    check_readback("ignored");
  endtask

  task automatic test_reset_mid_show();
    run_round(3, RDY + 2, 1'b0, 1'b1, -1, -1, LED_START + 7);
    checks += 4;
    if (led !== '0)         begin errors++; $display("FAIL midrst_led got %b exp 0", led); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    if (seq_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", seq_ready); end
    if (rd_sym !== '0)      begin errors++; $display("FAIL midrst_rd_sym got %0d exp 0", rd_sym); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < SEQ_LEN; i++) begin
      rd_idx = IW'(i);
      @(posedge clk);
      #1;
      checks++;
      if (rd_sym !== '0) begin
        errors++;
        $display("FAIL midrst_buf[%0d] got %0d exp 0", i, rd_sym);
      end
      @(negedge clk);
    end
    run_round(0, RDY + 2, 1'b0, 1'b0, -1, -1, -1);
    check_readback("after_rst");
  endtask

  task automatic test_held_start();
    run_round(3, 2 * RDY + 2, 1'b1, 1'b1, -1, -1, -1);
    check_readback("held");
  endtask

  initial begin
    test_reset();
    test_const_a6();
    test_pattern();
    test_real_lfsr();
    test_start_ignored();
    test_reset_mid_show();
    test_held_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_builder.md
Name: seq_builder

Overview:
- Consumes the free-running 8-bit LFSR output and builds the round's secret symbol sequence by sampling it at a fixed stride.
- Stores the sequence, then plays it to the one-hot LED bank with hold and gap timing.
- Exposes a registered read port so the downstream input checker can compare user presses against stored symbols.
- Sits between the LFSR and the game controller/checker.

Parameters:
- SEQ_LEN, 8: number of symbols per round (power of two, ≥2).
- SYM_W, 2: bits per symbol; LED bank width is 2**SYM_W.
- STRIDE, 8: clk cycles between LFSR samples (8 = fully refreshed byte).
- HOLD_CYCLES, 25000000: cycles each symbol's LED is lit.
- GAP_CYCLES, 12500000: dark cycles after each symbol.

Ports:
- clk  in  1  on-board 50 MHz clock.
- reset  in  1  synchronous, active-low reset.
- lfsr_in  in  8  registered LFSR state.
- start  in  1  level sampled each edge; high in IDLE or DONE begins a new round.
- rd_idx  in  clog2(SEQ_LEN)  checker read address.
- rd_sym  out  SYM_W  stored symbol at rd_idx, 1-cycle latency.
- led  out  2**SYM_W  one-hot symbol display, all-zero when dark.
- busy  out  1  high in CAPTURE and SHOW.
- seq_ready  out  1  high in DONE; the sequence is valid for checking.

Behaviour:
- Reset behaviour:
  - Reset is synchronous and active-low; clock is clk.
  - Reset low at any edge, including mid-CAPTURE or mid-SHOW, forces IDLE.
  - It clears led, busy, seq_ready, rd_sym, all counters and all buffer entries to 0.
- States and transitions: IDLE, CAPTURE, SHOW_ON, SHOW_OFF, DONE.
- IDLE:
  - Outputs are 0.
  - start=1 at edge E0: go to CAPTURE, set stride_cnt=0, sym_idx=0, busy=1.
- CAPTURE:
  - stride_cnt increments every cycle.
  - When stride_cnt==STRIDE-1: buf[sym_idx] <= lfsr_in[SYM_W-1:0], stride_cnt <= 0, sym_idx++.
  - Symbol i is therefore captured at edge E0+STRIDE*(i+1).
  - The edge capturing symbol SEQ_LEN-1 moves to SHOW_ON with sym_idx=0 and timer=0.
- SHOW_ON:
  - led = one-hot(buf[sym_idx]), registered, so it is visible from edge E0+STRIDE*SEQ_LEN+1.
  - Held for exactly HOLD_CYCLES cycles, then SHOW_OFF with timer=0.
- SHOW_OFF:
  - led=0 for exactly GAP_CYCLES cycles.
  - If sym_idx≠SEQ_LEN-1: sym_idx++ and return to SHOW_ON.
  - Otherwise go to DONE.
- DONE:
  - busy=0 and seq_ready=1.
  - seq_ready first reads high at edge E0+STRIDE*SEQ_LEN+1+SEQ_LEN*(HOLD_CYCLES+GAP_CYCLES).
  - start=1 clears seq_ready the next edge and enters CAPTURE; the buffer is overwritten progressively.
- start rules:
  - start is ignored in CAPTURE, SHOW_ON and SHOW_OFF.
  - A held start re-triggers only from IDLE or DONE.
- rd_sym:
  - rd_sym <= buf[rd_idx] every edge, regardless of state.
  - It is meaningful only when seq_ready=1.
  - A read in the same cycle as a buffer write returns the old value.
- Counter widths:
  - clog2 of each terminal count; no counter may wrap before its compare.
  - HOLD_CYCLES and GAP_CYCLES ≥1; GAP_CYCLES=0 is not supported.
- Symbol 0 maps to led[0]; symbol k maps to led[k].

Decomposition:
- Shared header bombsquad_defs.vh holds:
  - state encodings (IDLE=0, CAPTURE=1, SHOW_ON=2, SHOW_OFF=3, DONE=4);
  - SYM_W and SEQ_LEN defaults, shared with the checker.
- One sub-module, cycle_timer:
  - parameterised terminal count, with clear and enable inputs and a done pulse;
  - instantiated for the stride and for the hold/gap timing.
- Buffer and FSM stay in seq_builder.

Test Plan:
All scenarios use SEQ_LEN=4, SYM_W=2, STRIDE=8, HOLD_CYCLES=4, GAP_CYCLES=2.
1. lfsr_in held 8'hA6, start pulse at E0:
   - every symbol is 2'b10;
   - led=4'b0100 for 4 cycles and 4'b0000 for 2 cycles, repeated 4 times;
   - led first goes high at E0+33, and seq_ready rises at E0+57.
2. Bench drives lfsr_in so the low bits at capture edges E0+8/16/24/32 are 0,3,1,2:
   - rd_idx 0..3 in DONE returns 0,3,1,2 one cycle after each address;
   - led sequence is 0001, 1000, 0010, 0100.
3. Real LFSR8bit instance as source, reset released then start:
   - symbols match the LFSR low bits at the stride edges, computed by the bench model.
4. start re-asserted mid-CAPTURE and mid-SHOW_ON:
   - no restart and unchanged timing;
   - a start in DONE begins a new round with seq_ready=0 one edge later.
5. reset low for one edge during SHOW_ON:
   - next cycle led=0, busy=0, seq_ready=0, rd_sym=0 for every rd_idx;
   - a subsequent start behaves as scenario 1.
6. start held high continuously:
   - a round completes, one DONE cycle shows seq_ready=1, then a new round starts.
